mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Instruction encoder and program loader: the producing end of the opcode/field interface that the processor's control decoder consumes.
- Accepts symbolic instruction requests (mnemonic code plus register, immediate and target fields) over a valid/ready handshake.
- Assembles each request into a 32-bit MIPS word and writes it sequentially into instruction memory through a registered write port.
- Used by the testbench and by the boot path to load programs before the core is released from reset.

Parameters:
- ADDR_WIDTH, 6, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- START_ADDR, 0, word address loaded into the address counter on start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load session.
- req_valid  in  1  request present.
- req_ready  out  1  encoder accepts the request this cycle.
- req_mnem  in  5  mnemonic code (see Behaviour).
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register and shift fields.
- req_imm  in  16  immediate or branch offset.
- req_target  in  26  jump target field.
- req_last  in  1  marks the final instruction of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_WIDTH+1  words written this session.
- busy  out  1  state is LOAD.
- done  out  1  sticky; program loaded.
- error  out  1  sticky; illegal mnemonic or overflow.

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_addr, mem_wdata, count, done and error.
- States: IDLE, LOAD, DONE, ERROR.
  - IDLE to LOAD on start.
  - start in any state (LOAD included) returns to LOAD, sets the address to START_ADDR, clears count, done and error, and squashes any write scheduled for the next cycle. start has priority over a same-cycle handshake, and that request is not accepted.
- Handshake: req_ready = (state==LOAD) && !start.
  - Transfer occurs when req_valid && req_ready.
  - The request fields must stay stable while req_valid=1 and req_ready=0.
- Latency: a transfer in cycle N produces mem_we=1 in cycle N+1, with mem_wdata = encoded word and mem_addr = current address.
  - The address increments (wrapping modulo 2^ADDR_WIDTH) and count increments after each write.
  - mem_we is 1 for exactly one cycle per accepted legal request. Back-to-back transfers give one write per cycle.
- Mnemonic codes (R-type opcode 0x00 with the funct shown; other types with the opcode shown):
  - R-type: 0 ADD 0x20, 1 SUB 0x22, 2 AND 0x24, 3 OR 0x25, 4 NOR 0x27, 5 SLT 0x2A, 6 SLL 0x00, 7 SRL 0x02, 8 JR 0x08.
  - I-type: 9 ADDI 0x08, 10 ORI 0x0D, 11 LUI 0x0F, 12 BEQ 0x04, 13 BNE 0x05, 14 ANDI 0x0C, 15 LW 0x23, 16 SW 0x2B.
  - J-type: 17 J 0x02, 18 JAL 0x03.
  - Codes 19 to 31 are illegal.
- Encoding rules:
  - R-type = {6'h00, rs, rt, rd, shamt, funct}.
  - shamt is forced to 0 except for SLL/SRL; rs is forced to 0 for SLL/SRL; rt, rd and shamt are forced to 0 for JR.
  - I-type = {op, rs, rt, imm}; rs is forced to 0 for LUI.
  - J-type = {op, target}.
- Illegal mnemonic: the handshake completes, no write is issued, and the next state is ERROR with error=1.
- req_last on a legal request: the write is issued at N+1, and the next state after the write is DONE with done=1. req_ready is 0 from the cycle after the transfer onward.
- Overflow: if count reaches 2^ADDR_WIDTH without req_last, the state becomes ERROR with error=1 in the cycle after the final write. A full memory with req_last on the final word is DONE, not ERROR.
- In DONE and ERROR, req_ready=0; only start or reset leaves these states.
- busy = (state==LOAD).

Test Plan:
- start; ADD rs=9 rt=10 rd=8 shamt=3 (last=0) -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x012A4020 (shamt masked), count=1.
- ADDI rs=0 rt=8 imm=0x0005, then LUI rs=7 rt=1 imm=0x1001 back-to-back -> writes 0x20080005 @0 and 0x3C011001 @1 on consecutive cycles.
- BEQ rs=8 rt=9 imm=0xFFFE, then J target=0x0100008 with last=1 -> 0x1109FFFE @0 and 0x08100008 @1; done=1, busy=0, req_ready=0.
- Illegal mnemonic 25 with valid held -> accepted once, no mem_we, error=1, req_ready=0. A following start clears error and restarts at START_ADDR.
- ADDR_WIDTH=2, five requests without last -> four writes @0..3, error=1 after the fourth, fifth not accepted, count=4.
- start asserted the cycle after a transfer mid-stream -> no mem_we that cycle, count=0, next write goes to START_ADDR.

Source files
------------

// File: rtl/mips_instr_encoder_if.sv
// Request channel of the instruction encoder: one symbolic instruction
// per valid/ready transfer.
interface mips_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_mnem;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_shamt;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        req_last;

    modport master (
        output req_valid, req_mnem, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_mnem, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, req_last,
        output req_ready
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder / program loader. Accepts symbolic requests,
// assembles 32-bit MIPS words and writes them sequentially into
// instruction memory through a registered write port.
module mips_instr_encoder #(
    parameter int ADDR_WIDTH = 6,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    mips_instr_encoder_if.slave   req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
    typedef enum logic [1:0] {K_BAD, K_R, K_I, K_J} kind_t;

    localparam logic [4:0] M_SLL = 5'd6;
    localparam logic [4:0] M_SRL = 5'd7;
    localparam logic [4:0] M_JR  = 5'd8;
    localparam logic [4:0] M_LUI = 5'd11;

    // Count value that, once incremented by a write, fills the memory.
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    // A transfer that ends the session leaves LOAD only after its write
    // cycle; these flags close the handshake during that write cycle.
    logic                  last_pend_reg;
    logic                  ovf_pend_reg;

    kind_t       kind;
    logic [5:0]  opfn;
    logic [4:0]  rs_f, rt_f, rd_f, sh_f;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        xfer;

    assign req.req_ready = (state_reg == LOAD) && !start && !last_pend_reg && !ovf_pend_reg;
    assign xfer          = req.req_valid && req.req_ready;

    // Mnemonic decode and field assembly of the encoded word.
    always_comb begin
        kind = K_BAD;
        opfn = 6'h00;
        case (req.req_mnem)
            5'd0:  begin kind = K_R; opfn = 6'h20; end
            5'd1:  begin kind = K_R; opfn = 6'h22; end
            5'd2:  begin kind = K_R; opfn = 6'h24; end
            5'd3:  begin kind = K_R; opfn = 6'h25; end
            5'd4:  begin kind = K_R; opfn = 6'h27; end
            5'd5:  begin kind = K_R; opfn = 6'h2A; end
            5'd6:  begin kind = K_R; opfn = 6'h00; end
            5'd7:  begin kind = K_R; opfn = 6'h02; end
            5'd8:  begin kind = K_R; opfn = 6'h08; end
            5'd9:  begin kind = K_I; opfn = 6'h08; end
            5'd10: begin kind = K_I; opfn = 6'h0D; end
            5'd11: begin kind = K_I; opfn = 6'h0F; end
            5'd12: begin kind = K_I; opfn = 6'h04; end
            5'd13: begin kind = K_I; opfn = 6'h05; end
            5'd14: begin kind = K_I; opfn = 6'h0C; end
            5'd15: begin kind = K_I; opfn = 6'h23; end
            5'd16: begin kind = K_I; opfn = 6'h2B; end
            5'd17: begin kind = K_J; opfn = 6'h02; end
            5'd18: begin kind = K_J; opfn = 6'h03; end
            default: begin kind = K_BAD; opfn = 6'h00; end
        endcase

        // Unused fields are zeroed so the word is canonical.
        rs_f = req.req_rs;
        rt_f = req.req_rt;
        rd_f = req.req_rd;
        sh_f = 5'd0;
        if (req.req_mnem == M_SLL || req.req_mnem == M_SRL) begin
            sh_f = req.req_shamt;
            rs_f = 5'd0;
        end
        if (req.req_mnem == M_JR) begin
            rt_f = 5'd0;
            rd_f = 5'd0;
        end
        if (req.req_mnem == M_LUI) begin
            rs_f = 5'd0;
        end

        case (kind)
            K_R:     enc_word = {6'h00, rs_f, rt_f, rd_f, sh_f, opfn};
            K_I:     enc_word = {opfn, rs_f, rt_f, req.req_imm};
            K_J:     enc_word = {opfn, req.req_target};
            default: enc_word = 32'h0;
        endcase
        enc_legal = (kind != K_BAD);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start restarts the session from any state.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (last_pend_reg) begin
                        state_next = DONE;
                    end else if (ovf_pend_reg) begin
                        state_next = ERROR;
                    end else if (xfer && !enc_legal) begin
                        state_next = ERROR;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // Write port, address/count tracking and end-of-session flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            count_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 32'h0;
            last_pend_reg <= 1'b0;
            ovf_pend_reg  <= 1'b0;
        end else if (start) begin
            addr_reg      <= ADDR_WIDTH'(START_ADDR);
            count_reg     <= '0;
            mem_we_reg    <= 1'b0;
            last_pend_reg <= 1'b0;
            ovf_pend_reg  <= 1'b0;
        end else begin
            mem_we_reg    <= 1'b0;
            last_pend_reg <= 1'b0;
            ovf_pend_reg  <= 1'b0;
            if (xfer && enc_legal) begin
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= enc_word;
                addr_reg      <= addr_reg + 1'b1;
                count_reg     <= count_reg + 1'b1;
                last_pend_reg <= req.req_last;
                ovf_pend_reg  <= !req.req_last && (count_reg == LAST_SLOT);
            end
        end
    end

    // A restart in the write cycle cancels that write.
    assign mem_we    = mem_we_reg && !start;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign count     = count_reg;
    assign busy      = (state_reg == LOAD);
    assign done      = (state_reg == DONE);
    assign error     = (state_reg == ERROR);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed testbench for mips_instr_encoder: a default-size instance and a
// 4-word instance for the overflow / full-memory boundaries.
module tb_mips_instr_encoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;

    always #5 clk = ~clk;

    mips_instr_encoder_if bus();
    mips_instr_encoder_if bus2();

    logic        mem_we, busy, done, error;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;

    logic        mem_we2, busy2, done2, error2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  count2;

    mips_instr_encoder u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .req       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    mips_instr_encoder #(.ADDR_WIDTH(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .req       (bus2),
        .mem_we    (mem_we2),
        .mem_addr  (mem_addr2),
        .mem_wdata (mem_wdata2),
        .count     (count2),
        .busy      (busy2),
        .done      (done2),
        .error     (error2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [4:0] mn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic last);
        if (!sel) begin
            bus.req_valid = v;   bus.req_mnem = mn;  bus.req_rs = rs;  bus.req_rt = rt;
            bus.req_rd = rd;     bus.req_shamt = sh; bus.req_imm = imm;
            bus.req_target = tgt; bus.req_last = last;
        end else begin
            bus2.req_valid = v;  bus2.req_mnem = mn; bus2.req_rs = rs; bus2.req_rt = rt;
            bus2.req_rd = rd;    bus2.req_shamt = sh; bus2.req_imm = imm;
            bus2.req_target = tgt; bus2.req_last = last;
        end
    endtask

    task automatic idle_req(input bit sel);
        drive(sel, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    endtask

    // Ends one time unit after a negedge, with start released.
    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1;
        else     start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        #1;
    endtask

    // Single isolated transfer on the default instance, write checked next cycle.
    task automatic one_shot(input string tag, input logic [4:0] mn, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [25:0] tgt,
                            input logic [31:0] exp_word, input logic [5:0] exp_addr);
        drive(1'b0, 1'b1, mn, rs, rt, rd, sh, imm, tgt, 1'b0);
        @(negedge clk); #1;
        idle_req(1'b0);
        check({tag, ".we"},   32'(mem_we),   32'd1);
        check({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, ".data"}, mem_wdata,     exp_word);
    endtask

    initial begin
        idle_req(1'b0);
        idle_req(1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst.we",    32'(mem_we),        32'd0);
        check("rst.addr",  32'(mem_addr),      32'd0);
        check("rst.wdata", mem_wdata,          32'd0);
        check("rst.count", 32'(count),         32'd0);
        check("rst.busy",  32'(busy),          32'd0);
        check("rst.done",  32'(done),          32'd0);
        check("rst.error", 32'(error),         32'd0);
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        check("rst.count2", 32'(count2),       32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Mnemonic table, one transfer at a time
        pulse_start(1'b0);
        check("start.busy",  32'(busy),          32'd1);
        check("start.ready", 32'(bus.req_ready), 32'd1);
        check("start.count", 32'(count),         32'd0);
        one_shot("add", 5'd0,  5'd9,  5'd10, 5'd8, 5'd3, 16'd0, 26'd0, 32'h012A4020, 6'd0);
        check("add.count", 32'(count), 32'd1);
        one_shot("sll", 5'd6,  5'd5,  5'd3,  5'd4, 5'd2, 16'd0, 26'd0, 32'h00032080, 6'd1);
        one_shot("jr",  5'd8,  5'd31, 5'd3,  5'd4, 5'd2, 16'd0, 26'd0, 32'h03E00008, 6'd2);
        one_shot("sw",  5'd16, 5'd29, 5'd8,  5'd0, 5'd0, 16'h0004, 26'd0, 32'hAFA80004, 6'd3);
        one_shot("jal", 5'd18, 5'd0,  5'd0,  5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 32'h0FFFFFFF, 6'd4);
        check("tbl.count", 32'(count), 32'd5);
        @(negedge clk); #1;
        check("tbl.we_idle", 32'(mem_we), 32'd0);

        // Back-to-back ADDI then LUI
        pulse_start(1'b0);
        drive(1'b0, 1'b1, 5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b0);
        @(negedge clk); #1;
        drive(1'b0, 1'b1, 5'd11, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1001, 26'd0, 1'b0);
        check("addi.we",   32'(mem_we),   32'd1);
        check("addi.addr", 32'(mem_addr), 32'd0);
        check("addi.data", mem_wdata,     32'h20080005);
        @(negedge clk); #1;
        idle_req(1'b0);
        check("lui.we",    32'(mem_we),   32'd1);
        check("lui.addr",  32'(mem_addr), 32'd1);
        check("lui.data",  mem_wdata,     32'h3C011001);
        check("lui.count", 32'(count),    32'd2);
        @(negedge clk); #1;
        check("b2b.we_idle", 32'(mem_we), 32'd0);

        // BEQ then J with last
        pulse_start(1'b0);
        drive(1'b0, 1'b1, 5'd12, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b0);
        @(negedge clk); #1;
        drive(1'b0, 1'b1, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100008, 1'b1);
        check("beq.addr", 32'(mem_addr), 32'd0);
        check("beq.data", mem_wdata,     32'h1109FFFE);
        @(negedge clk); #1;
        drive(1'b0, 1'b1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0);
        check("j.we",    32'(mem_we),          32'd1);
        check("j.addr",  32'(mem_addr),        32'd1);
        check("j.data",  mem_wdata,            32'h08100008);
        check("j.ready", 32'(bus.req_ready),   32'd0);
        @(negedge clk); #1;
        check("last.done",  32'(done),          32'd1);
        check("last.busy",  32'(busy),          32'd0);
        check("last.ready", 32'(bus.req_ready), 32'd0);
        check("last.we",    32'(mem_we),        32'd0);
        check("last.count", 32'(count),         32'd2);
        idle_req(1'b0);

        // Illegal mnemonic held valid, then restart
        pulse_start(1'b0);
        drive(1'b0, 1'b1, 5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        @(negedge clk); #1;
        check("ill.we",    32'(mem_we),        32'd0);
        check("ill.error", 32'(error),         32'd1);
        check("ill.ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk); #1;
        check("ill.we2",   32'(mem_we),        32'd0);
        check("ill.count", 32'(count),         32'd0);
        idle_req(1'b0);
        pulse_start(1'b0);
        check("ill.clear", 32'(error), 32'd0);
        check("ill.busy",  32'(busy),  32'd1);
        one_shot("rst_add", 5'd0, 5'd9, 5'd10, 5'd8, 5'd3, 16'd0, 26'd0, 32'h012A4020, 6'd0);

        // start the cycle after a transfer squashes that write
        pulse_start(1'b0);
        one_shot("sq.a", 5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h00221825, 6'd0);
        one_shot("sq.b", 5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, 32'h00853022, 6'd1);
        drive(1'b0, 1'b1, 5'd2, 5'd7, 5'd8, 5'd9, 5'd0, 16'd0, 26'd0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        idle_req(1'b0);
        #1;
        check("sq.we_squashed", 32'(mem_we), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("sq.count", 32'(count),  32'd0);
        check("sq.busy",  32'(busy),   32'd1);
        check("sq.we",    32'(mem_we), 32'd0);
        one_shot("sq.d", 5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h0022182A, 6'd0);

        // Overflow on the 4-word instance
        pulse_start(1'b1);
        drive(1'b1, 1'b1, 5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            check($sformatf("ovf.we%0d", k-1),   32'(mem_we2),   32'd1);
            check($sformatf("ovf.addr%0d", k-1), 32'(mem_addr2), 32'(k-1));
            check($sformatf("ovf.data%0d", k-1), mem_wdata2,     32'h34220000 + 32'(k-1));
            drive(1'b1, 1'b1, 5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'(k), 26'd0, 1'b0);
        end
        check("ovf.ready",  32'(bus2.req_ready), 32'd0);
        check("ovf.count",  32'(count2),         32'd4);
        @(negedge clk); #1;
        check("ovf.error",  32'(error2),         32'd1);
        check("ovf.we",     32'(mem_we2),        32'd0);
        check("ovf.ready2", 32'(bus2.req_ready), 32'd0);
        @(negedge clk); #1;
        check("ovf.we_5th", 32'(mem_we2),        32'd0);
        check("ovf.count2", 32'(count2),         32'd4);
        idle_req(1'b1);

        // Full memory with last on the final word ends in DONE
        pulse_start(1'b1);
        check("full.error_clr", 32'(error2), 32'd0);
        drive(1'b1, 1'b1, 5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            check($sformatf("full.addr%0d", k-1), 32'(mem_addr2), 32'(k-1));
            if (k < 4)
                drive(1'b1, 1'b1, 5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'(k), 26'd0, (k == 3) ? 1'b1 : 1'b0);
            else
                idle_req(1'b1);
        end
        @(negedge clk); #1;
        check("full.done",  32'(done2),  32'd1);
        check("full.error", 32'(error2), 32'd0);
        check("full.count", 32'(count2), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
